// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder computing A + B + cin one full-adder slice per clock.
// Operands are captured into shift registers on the accepting edge. The sum is
// built LSB-first in a shift register and is published to sum_o/cout_o/ovf_o only
// on the final slice, so the outputs never show a partial result.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             slice_s, slice_c;

  // One-bit full-adder slice on the current LSBs and the running carry.
  always_comb begin
    slice_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    slice_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
  end

  // Next-state and datapath update; everything holds unless the state says otherwise.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_sr_d   = a_i;
          b_sr_d   = b_i;
          sum_sr_d = '0;
          carry_d  = cin_i;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        sum_sr_d = {slice_s, sum_sr_q[WIDTH-1:1]};
        carry_d  = slice_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // carry_q here is the carry into the MSB, slice_c the carry out of it
          sum_d   = {slice_s, sum_sr_q[WIDTH-1:1]};
          cout_d  = slice_c;
          ovf_d   = carry_q ^ slice_c;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  // Status flags decode straight from the state register.
  always_comb begin
    busy_o = (state_q != IDLE);
    done_o = (state_q == DONE);
    sum_o  = sum_q;
    cout_o = cout_q;
    ovf_o  = ovf_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors with hand-computed results; expected results
// are queued at issue time and a negedge monitor pops one per done_o pulse.
module tb_serial_adder;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic       cin_i;
  logic       busy_o;
  logic       done_o;
  logic [7:0] sum_o;
  logic       cout_o;
  logic       ovf_o;

  exp_t       sb_q[$];
  int         tests_run = 0;
  int         failures  = 0;
  logic [7:0] last_sum  = 8'h00;

  serial_adder #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .cin_i   (cin_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .sum_o   (sum_o),
    .cout_o  (cout_o),
    .ovf_o   (ovf_o)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every completion pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        checkOutput("done_without_expectation", 32'd0, 32'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("sum", {24'd0, sum_o}, {24'd0, e.sum});
        checkOutput("cout", {31'd0, cout_o}, {31'd0, e.cout});
        checkOutput("ovf", {31'd0, ovf_o}, {31'd0, e.ovf});
      end
    end
  end

  task automatic waitIdle();
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!busy_o) return;
    end
    checkOutput("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  // Issue one operation, scramble inputs after acceptance, check latency and busy length.
  // poke > 0 pulses start_i with other operands after that many RUN edges.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c,
                               input logic [7:0] es, input logic ec, input logic eo,
                               input int poke);
    int lat;
    int busy_cnt;
    exp_t e;
    waitIdle();
    a_i = a; b_i = b; cin_i = c; start_i = 1'b1;
    e.sum = es; e.cout = ec; e.ovf = eo;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start_i = 1'b0;
    a_i = ~a; b_i = ~b; cin_i = ~c;
    checkOutput("busy_after_accept", {31'd0, busy_o}, 32'd1);
    checkOutput("sum_hold", {24'd0, sum_o}, {24'd0, last_sum});
    lat = 0;
    busy_cnt = 1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == poke) begin
        start_i = 1'b1; a_i = 8'hAA; b_i = 8'h55;
      end else begin
        start_i = 1'b0;
      end
      if (done_o && lat == 0) lat = n;
      if (busy_o) busy_cnt++;
      else break;
    end
    start_i = 1'b0;
    checkOutput("done_latency", lat, 32'd8);
    checkOutput("busy_cycles", busy_cnt, 32'd9);
    last_sum = es;
  endtask

  initial begin
    logic [7:0] sum_pat;
    logic [7:0] carry_pat;
    int n1;
    int n2;
    exp_t e;
    sum_pat   = 8'b01101001;
    carry_pat = 8'b00010111;
    rst_n = 1'b0; start_i = 1'b0; a_i = 8'h00; b_i = 8'h00; cin_i = 1'b0;
    #12;
    checkOutput("reset_sum", {24'd0, sum_o}, 32'd0);
    checkOutput("reset_flags", {28'd0, busy_o, done_o, cout_o, ovf_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0);
    applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    applyStimulus(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    applyStimulus(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
    applyStimulus(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 0);

    // start pulsed mid-RUN with new operands is ignored
    applyStimulus(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 3);

    // start held high: back-to-back operations WIDTH+2 edges apart
    waitIdle();
    a_i = 8'h05; b_i = 8'h03; cin_i = 1'b0; start_i = 1'b1;
    e.sum = 8'h08; e.cout = 1'b0; e.ovf = 1'b0; sb_q.push_back(e);
    e.sum = 8'h80; e.cout = 1'b0; e.ovf = 1'b1; sb_q.push_back(e);
    @(posedge clk); #1;
    n1 = 0; n2 = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done_o && n1 == 0) begin
        n1 = n;
        a_i = 8'h40; b_i = 8'h40;
      end else if (done_o && n1 != 0) begin
        n2 = n;
        break;
      end
    end
    start_i = 1'b0;
    checkOutput("held_start_first_done", n1, 32'd8);
    checkOutput("held_start_second_done", n2, 32'd18);
    last_sum = 8'h80;

    // reset during RUN aborts without a done pulse
    waitIdle();
    a_i = 8'h33; b_i = 8'h11; cin_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_sum", {24'd0, sum_o}, 32'd0);
    checkOutput("async_reset_flags", {28'd0, busy_o, done_o, cout_o, ovf_o}, 32'd0);
    last_sum = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("idle_after_reset", {31'd0, busy_o}, 32'd0);
    applyStimulus(8'h0F, 8'hF1, 1'b0, 8'h00, 1'b1, 1'b0, 0);

    // full-adder truth table on the LSBs; patterns are indexed MSB-first by {a,b,cin}
    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = 3'(i);
      applyStimulus({7'd0, idx[2]}, {7'd0, idx[1]}, idx[0],
                    {6'd0, carry_pat[7-i], sum_pat[7-i]}, 1'b0, 1'b0, 0);
    end

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/sum width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_i  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port a_i  input  WIDTH  operand A; captured when start is accepted.
REQ-006 SHALL have port b_i  input  WIDTH  operand B; captured when start is accepted.
REQ-007 SHALL have port cin_i  input  1  carry-in; captured when start is accepted.
REQ-008 SHALL have port busy_o  output  1  high in RUN and DONE.
REQ-009 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-010 SHALL have port sum_o  output  WIDTH  registered result A+B+cin, modulo 2^WIDTH.
REQ-011 SHALL have port cout_o  output  1  registered carry out of the MSB.
REQ-012 SHALL have port ovf_o  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-014 IDLE: start_i=1 at edge T0 -> load A/B shift registers, carry reg <= cin_i, bit counter <= 0, state <= RUN; start_i=0 -> stay IDLE.
REQ-015 RUN: each edge, one 1-bit full-adder slice on (A_sr[0], B_sr[0], carry): sum bit shifted into MSB of sum shift register, A_sr/B_sr shifted right by 1, carry <= slice carry-out, counter +1.
REQ-016 Slice SHALL compute sum = a^b^c, carry = (a&b)|(a&c)|(b&c); no '+' operator on full WIDTH operands.
REQ-017 Bit i (LSB = 0) SHALL be processed at edge T(i+1); the carry produced at edge T(WIDTH-1) SHALL be retained as the MSB carry-in for overflow.
REQ-018 At edge T(WIDTH), the last bit is processed; sum_o, cout_o, ovf_o are loaded from the final values; state <= DONE.
REQ-019 DONE: done_o=1 for exactly one cycle (T(WIDTH) to T(WIDTH+1)); state <= IDLE at next edge unconditionally.
REQ-020 Latency: done_o asserts WIDTH edges after the accepting edge; throughput one operation per WIDTH+2 cycles.
REQ-021 start_i in RUN or DONE SHALL be ignored; operand/cin changes after acceptance SHALL not affect the result.
REQ-022 start_i held high continuously SHALL start a new operation at the first IDLE edge after DONE.
REQ-023 sum_o/cout_o/ovf_o SHALL hold the last completed result until the next completion; they never show partial sums.
REQ-024 Counter width SHALL be clog2(WIDTH)+1 bits; RUN terminates on counter == WIDTH-1 at the processing edge, no wrap.
REQ-025 busy_o and done_o SHALL be decoded directly from state registers (glitch-free, no combinational path from inputs).

Reset
REQ-026 rst_n low SHALL immediately, independent of clk: state <= IDLE; sum_o, cout_o, ovf_o, done_o, busy_o, shift registers, carry, and counter <= 0.
REQ-027 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done_o pulse; first edge after rst_n rises behaves as IDLE.

Verification
REQ-028 WIDTH=8, a=0x01, b=0x01, cin=0 -> sum_o=0x02, cout_o=0, ovf_o=0, done_o high exactly 8 edges after the accepting edge, busy_o high for 9 cycles.
REQ-029 a=0xFF, b=0x01, cin=0 -> sum_o=0x00, cout_o=1, ovf_o=0.
REQ-030 a=0x7F, b=0x01, cin=0 -> sum_o=0x80, cout_o=0, ovf_o=1; then a=0x80, b=0x80 -> sum_o=0x00, cout_o=1, ovf_o=1.
REQ-031 a=0xFF, b=0xFF, cin=1 -> sum_o=0xFF, cout_o=1, ovf_o=0; a=0x00, b=0x00, cin=1 -> sum_o=0x01.
REQ-032 Start a=0x10, b=0x20; at cycle 3 of RUN pulse start_i with a=0xAA, b=0x55 and change a_i/b_i -> result 0x30 only, one done_o pulse.
REQ-033 rst_n low during cycle 4 of RUN -> outputs 0 asynchronously, no done_o; after release, a=0x0F, b=0xF1 -> sum_o=0x00, cout_o=1; also an exhaustive 3-bit sweep over the 8 (a,b,cin) combinations using LSB operands matches sum pattern 0b01101001 and carry 0b00010111.
